// File: rtl/switch_debouncer_if.sv
// Switch bundle between the raw slide switches and the debounced consumers.
// The master drives the raw levels; the slave (debouncer) returns the clean word.
interface switch_debouncer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] SW_in;
    logic [WIDTH-1:0] SW_out;
    logic             SW_changed;
    logic             SW_valid;

    modport master (
        output SW_in,
        input  SW_out,
        input  SW_changed,
        input  SW_valid
    );

    modport slave (
        input  SW_in,
        output SW_out,
        output SW_changed,
        output SW_valid
    );
endinterface

// File: rtl/switch_debouncer.sv
// Per-bit synchroniser plus consecutive-mismatch counter debouncer for slide switches.
// Emits a stable word, a one-cycle change pulse and a sticky start-up valid flag.
module switch_debouncer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    switch_debouncer_if.slave sw
);
    localparam int CNT_W        = $clog2(DEBOUNCE_CYCLES);
    localparam int START_TARGET = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int ST_W         = $clog2(START_TARGET + 1);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0]  START_LAST = ST_W'(START_TARGET);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] out_q, out_d;
    logic             changed_q, changed_d;
    logic             valid_q, valid_d;
    logic [ST_W-1:0]  start_q, start_d;

    genvar gi;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sw.SW_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    // A counter only advances while its bit disagrees; any agreement or an accepted update clears it.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             mismatch;
            logic             at_last;

            assign mismatch  = sync_last[gi] ^ out_q[gi];
            assign at_last   = (cnt_q == CNT_LAST);
            assign out_d[gi] = (mismatch && at_last) ? sync_last[gi] : out_q[gi];
            assign cnt_d     = (mismatch && !at_last) ? cnt_q + 1'b1 : '0;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_comb begin
        changed_d = |(out_d ^ out_q);
        start_d   = start_q;
        if (start_q != START_LAST) begin
            start_d = start_q + 1'b1;
        end
        valid_d = valid_q | (start_d == START_LAST);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q     <= '0;
            changed_q <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= '0;
        end else begin
            out_q     <= out_d;
            changed_q <= changed_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
        end
    end

    assign sw.SW_out     = out_q;
    assign sw.SW_changed = changed_q;
    assign sw.SW_valid   = valid_q;
endmodule
